// File: rtl/reservation_station_pkg.sv
// Shared widths, reset values and record types for the reservation station slice.
// The forwarding helper is used both at insertion and for resident entries.
package reservation_station_pkg;
    localparam int ROB_W    = 4;
    localparam int OPENUM_W = 6;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int RS_SIZE  = 8;
    localparam int IDX_W    = $clog2(RS_SIZE);
    localparam int CNT_W    = $clog2(RS_SIZE + 1);

    localparam logic [ROB_W-1:0]    ZERO_ROB   = '0;
    localparam logic [OPENUM_W-1:0] OPENUM_NOP = '0;

    typedef struct packed {
        logic                busy;
        logic [OPENUM_W-1:0] openum;
        logic [DATA_W-1:0]   v1;
        logic [DATA_W-1:0]   v2;
        logic [ROB_W-1:0]    q1;
        logic [ROB_W-1:0]    q2;
        logic [ADDR_W-1:0]   pc;
        logic [DATA_W-1:0]   imm;
        logic [ROB_W-1:0]    rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic                valid;
        logic [ROB_W-1:0]    rob_id;
        logic [DATA_W-1:0]   result;
    } cdb_t;

    typedef struct packed {
        logic [ROB_W-1:0]    q;
        logic [DATA_W-1:0]   v;
    } operand_t;

    typedef struct packed {
        logic                ena;
        logic [OPENUM_W-1:0] openum;
        logic [DATA_W-1:0]   v1;
        logic [DATA_W-1:0]   v2;
        logic [ADDR_W-1:0]   pc;
        logic [DATA_W-1:0]   imm;
        logic [ROB_W-1:0]    rob_id;
    } issue_t;

    // The arith bus wins when both buses broadcast the awaited tag.
    function automatic operand_t forward(input operand_t op, input cdb_t arith, input cdb_t ls);
        operand_t res;
        res = op;
        if (op.q != ZERO_ROB) begin
            if (arith.valid && arith.rob_id == op.q) begin
                res.q = ZERO_ROB;
                res.v = arith.result;
            end else if (ls.valid && ls.rob_id == op.q) begin
                res.q = ZERO_ROB;
                res.v = ls.result;
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder over the station slots.
module rs_pick
    import reservation_station_pkg::*;
(
    input  logic [RS_SIZE-1:0] req,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Eight-entry reservation station: captures dispatched ops, snoops both CDBs
// for missing operands and issues the oldest-slot ready op to the ALU.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                misbranch_flag,
    input  logic                ena_from_dsp,
    input  logic [OPENUM_W-1:0] openum_from_dsp,
    input  logic [DATA_W-1:0]   V1_from_dsp,
    input  logic [DATA_W-1:0]   V2_from_dsp,
    input  logic [ROB_W-1:0]    Q1_from_dsp,
    input  logic [ROB_W-1:0]    Q2_from_dsp,
    input  logic [ADDR_W-1:0]   pc_from_dsp,
    input  logic [DATA_W-1:0]   imm_from_dsp,
    input  logic [ROB_W-1:0]    rob_id_from_dsp,
    output logic                full_to_if,
    input  logic                valid_from_Arith_unit_cdb,
    input  logic [ROB_W-1:0]    rob_id_from_Arith_unit_cdb,
    input  logic [DATA_W-1:0]   result_from_Arith_unit_cdb,
    input  logic                valid_from_LS_unit_cdb,
    input  logic [ROB_W-1:0]    rob_id_from_LS_unit_cdb,
    input  logic [DATA_W-1:0]   result_from_LS_unit_cdb,
    output logic                ena_to_alu,
    output logic [OPENUM_W-1:0] openum_to_alu,
    output logic [DATA_W-1:0]   V1_to_alu,
    output logic [DATA_W-1:0]   V2_to_alu,
    output logic [ADDR_W-1:0]   pc_to_alu,
    output logic [DATA_W-1:0]   imm_to_alu,
    output logic [ROB_W-1:0]    rob_id_to_alu
);
    localparam issue_t ISSUE_RESET = '{ena: 1'b0, openum: OPENUM_NOP, v1: '0, v2: '0,
                                       pc: '0, imm: '0, rob_id: ZERO_ROB};

    rs_entry_t          entry_q [RS_SIZE];
    rs_entry_t          entry_d [RS_SIZE];
    issue_t             issue_q, issue_d;
    cdb_t               arith_cdb, ls_cdb;
    operand_t           wake1, wake2;
    logic [RS_SIZE-1:0] free_vec, ready_vec;
    logic               free_found, ready_found;
    logic [IDX_W-1:0]   free_idx, ready_idx;
    logic [CNT_W-1:0]   free_cnt;

    assign arith_cdb = '{valid: valid_from_Arith_unit_cdb, rob_id: rob_id_from_Arith_unit_cdb,
                         result: result_from_Arith_unit_cdb};
    assign ls_cdb    = '{valid: valid_from_LS_unit_cdb, rob_id: rob_id_from_LS_unit_cdb,
                         result: result_from_LS_unit_cdb};

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = ~entry_q[i].busy;
            ready_vec[i] = entry_q[i].busy && entry_q[i].q1 == ZERO_ROB && entry_q[i].q2 == ZERO_ROB;
            free_cnt     = free_cnt + CNT_W'(free_vec[i]);
        end
    end

    // Two free slots are needed because the dispatcher has one op already in flight.
    assign full_to_if = (free_cnt < CNT_W'(2));

    rs_pick u_free_pick  (.req(free_vec),  .found(free_found),  .idx(free_idx));
    rs_pick u_ready_pick (.req(ready_vec), .found(ready_found), .idx(ready_idx));

    always_comb begin
        entry_d = entry_q;
        issue_d = issue_q;
        wake1   = '0;
        wake2   = '0;
        if (rdy) begin
            issue_d.ena = 1'b0;
            if (misbranch_flag) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entry_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entry_q[i].busy) begin
                        wake1 = forward('{q: entry_q[i].q1, v: entry_q[i].v1}, arith_cdb, ls_cdb);
                        wake2 = forward('{q: entry_q[i].q2, v: entry_q[i].v2}, arith_cdb, ls_cdb);
                        entry_d[i].q1 = wake1.q;
                        entry_d[i].v1 = wake1.v;
                        entry_d[i].q2 = wake2.q;
                        entry_d[i].v2 = wake2.v;
                    end
                end
                // Readiness is judged on pre-edge state, so same-edge wakeups wait a cycle.
                if (ready_found) begin
                    issue_d = '{ena: 1'b1, openum: entry_q[ready_idx].openum,
                                v1: entry_q[ready_idx].v1, v2: entry_q[ready_idx].v2,
                                pc: entry_q[ready_idx].pc, imm: entry_q[ready_idx].imm,
                                rob_id: entry_q[ready_idx].rob_id};
                    entry_d[ready_idx].busy = 1'b0;
                end
                if (ena_from_dsp && free_found) begin
                    wake1 = forward('{q: Q1_from_dsp, v: V1_from_dsp}, arith_cdb, ls_cdb);
                    wake2 = forward('{q: Q2_from_dsp, v: V2_from_dsp}, arith_cdb, ls_cdb);
                    entry_d[free_idx] = '{busy: 1'b1, openum: openum_from_dsp,
                                          v1: wake1.v, v2: wake2.v, q1: wake1.q, q2: wake2.q,
                                          pc: pc_from_dsp, imm: imm_from_dsp,
                                          rob_id: rob_id_from_dsp};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            issue_q <= ISSUE_RESET;
        end else begin
            entry_q <= entry_d;
            issue_q <= issue_d;
        end
    end

    assign ena_to_alu    = issue_q.ena;
    assign openum_to_alu = issue_q.openum;
    assign V1_to_alu     = issue_q.v1;
    assign V2_to_alu     = issue_q.v2;
    assign pc_to_alu     = issue_q.pc;
    assign imm_to_alu    = issue_q.imm;
    assign rob_id_to_alu = issue_q.rob_id;
endmodule
